// File: rtl/msg_pkg.sv
// msg_pkg: shared constants and frame-state encoding for the UART message framer
package msg_pkg;
  localparam logic [7:0] SYNC_BYTE     = 8'h7E;
  localparam logic [7:0] CMD_DM_ENABLE = 8'hA8;
  localparam logic [7:0] CMD_DM_SET    = 8'hAC;
  localparam int         BAUD_CYCLES   = 1736;
  typedef enum logic [1:0] {S_IDLE, S_LEN, S_BODY} frame_state_t;
endpackage

// File: rtl/msg_timeout_timer.sv
// msg_timeout_timer: saturating idle counter that flags a stalled frame
module msg_timeout_timer #(
  parameter int CYCLES = 52080
) (
  input  logic CLK,
  input  logic reset,
  input  logic clr,
  input  logic run,
  output logic expired
);
  localparam int W = $clog2(CYCLES + 1);
  logic [W-1:0] cnt;
  // count idle cycles while running, saturating at CYCLES
  always_ff @(posedge CLK or negedge reset)
    if (!reset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (run && cnt != W'(CYCLES)) cnt <= cnt + 1'b1;
  // expiry is seen on the edge that completes CYCLES idle cycles, so the error lands exactly CYCLES after the last byte
  assign expired = run && cnt >= W'(CYCLES - 1);
endmodule

// File: rtl/uart_msg_framer.sv
// uart_msg_framer: assembles SYNC/LEN/body byte frames into parallel command messages
module uart_msg_framer
  import msg_pkg::*;
#(
  parameter int MAX_LEN        = 10,
  parameter int TIMEOUT_CYCLES = 52080
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  input  logic                 rx_ferr,
  output logic                 msg_valid,
  output logic [7:0]           msg_cmd,
  output logic [3:0]           msg_len,
  output logic [8*MAX_LEN-1:0] msg_data,
  output logic                 msg_err,
  output logic                 busy
);
  localparam logic [7:0] MAX_B = 8'(MAX_LEN);
  frame_state_t state;
  logic [3:0] len, idx;
  logic [MAX_LEN-1:0][7:0] wbuf, wbuf_nxt;
  logic byte_ok, expired;
  assign byte_ok = rx_valid && !rx_ferr;
  assign busy = state != S_IDLE;
  // working buffer with the incoming body byte merged in, so commit can copy it in the same edge
  always_comb begin
    wbuf_nxt = wbuf;
    for (int j = 0; j < MAX_LEN; j++) if (idx == 4'(j)) wbuf_nxt[j] = rx_data;
  end
  msg_timeout_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timer (
    .CLK     (CLK),
    .reset   (reset),
    .clr     (byte_ok || state == S_IDLE),
    .run     (busy),
    .expired (expired)
  );
  // frame FSM: framing-error beats a byte, a byte beats timer expiry
  always_ff @(posedge CLK or negedge reset)
    if (!reset) begin
      state     <= S_IDLE;
      len       <= '0;
      idx       <= '0;
      wbuf      <= '0;
      msg_valid <= 1'b0;
      msg_err   <= 1'b0;
      msg_cmd   <= '0;
      msg_len   <= '0;
      msg_data  <= '0;
    end else begin
      msg_valid <= 1'b0;
      msg_err   <= 1'b0;
      unique case (state)
        S_IDLE: if (byte_ok && rx_data == SYNC_BYTE) state <= S_LEN;
        S_LEN:
          if (rx_ferr || (expired && !rx_valid)) begin
            msg_err <= 1'b1;
            state   <= S_IDLE;
          end else if (rx_valid) begin
            if (rx_data != 8'd0 && rx_data <= MAX_B) begin
              len   <= rx_data[3:0];
              wbuf  <= '0;
              idx   <= '0;
              state <= S_BODY;
            end else begin
              msg_err <= 1'b1;
              state   <= S_IDLE;
            end
          end
        S_BODY:
          if (rx_ferr || (expired && !rx_valid)) begin
            msg_err <= 1'b1;
            state   <= S_IDLE;
          end else if (rx_valid) begin
            wbuf <= wbuf_nxt;
            idx  <= idx + 4'd1;
            if (idx == len - 4'd1) begin
              msg_valid <= 1'b1;
              msg_cmd   <= wbuf_nxt[0];
              msg_len   <= len;
              msg_data  <= wbuf_nxt;
              state     <= S_IDLE;
            end
          end
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_msg_framer.sv
// tb_uart_msg_framer: scoreboard bench driving directed byte frames into the framer
module tb_uart_msg_framer;
  localparam int MAX_LEN = 10;
  localparam int T       = 52080;
  logic CLK = 1'b0, reset = 1'b0;
  logic [7:0] rx_data = '0;
  logic rx_valid = 1'b0, rx_ferr = 1'b0;
  logic msg_valid, msg_err, busy;
  logic [7:0] msg_cmd;
  logic [3:0] msg_len;
  logic [8*MAX_LEN-1:0] msg_data;
  int checks = 0, failures = 0, cyc = 0;
  typedef struct {
    bit          err;
    logic [7:0]  cmd;
    logic [3:0]  len;
    logic [79:0] data;
    int          at;
  } exp_t;
  exp_t q[$];

  uart_msg_framer #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYCLES(T)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ferr   (rx_ferr),
    .msg_valid (msg_valid),
    .msg_cmd   (msg_cmd),
    .msg_len   (msg_len),
    .msg_data  (msg_data),
    .msg_err   (msg_err),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [79:0] a, input logic [79:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, a, e);
    end
  endtask

  task automatic expect_ev(input bit err, input logic [7:0] cmd, input logic [3:0] len,
                           input logic [79:0] data, input int at = -1);
    exp_t e;
    e.err = err; e.cmd = cmd; e.len = len; e.data = data; e.at = at;
    q.push_back(e);
  endtask

  task automatic send(input logic [7:0] b, input logic f = 1'b0);
    @(negedge CLK);
    rx_data = b; rx_valid = 1'b1; rx_ferr = f;
    @(negedge CLK);
    rx_valid = 1'b0; rx_ferr = 1'b0;
  endtask

  task automatic ferr_pulse();
    @(negedge CLK);
    rx_ferr = 1'b1;
    @(negedge CLK);
    rx_ferr = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string n);
    chk({n, "_valid"}, msg_valid, 0);
    chk({n, "_err"}, msg_err, 0);
    chk({n, "_cmd"}, msg_cmd, 0);
    chk({n, "_len"}, msg_len, 0);
    chk({n, "_data"}, msg_data, 0);
    chk({n, "_busy"}, busy, 0);
  endtask

  // monitor: every strobe pops one expectation and compares the full message
  always @(negedge CLK)
    if (msg_valid || msg_err) begin
      exp_t e;
      chk("exclusive", msg_valid && msg_err, 0);
      if (q.size() == 0) chk("unexpected_strobe", {msg_valid, msg_err}, 0);
      else begin
        e = q.pop_front();
        chk("kind_err", msg_err, e.err);
        chk("msg_cmd", msg_cmd, e.cmd);
        chk("msg_len", msg_len, e.len);
        chk("msg_data", msg_data, e.data);
        if (e.at >= 0) chk("timeout_cycle", cyc, e.at);
      end
    end

  initial begin
    repeat (3) @(negedge CLK);
    chk_reset_outputs("reset");
    reset = 1'b1;
    // test 1
    send(8'h7E); send(8'h04);
    expect_ev(0, 8'hA8, 4, 80'h000000A8);
    send(8'hA8); send(8'h00); send(8'h00); send(8'h00);
    // test 2, then a stray idle byte
    expect_ev(0, 8'hAC, 4, 80'h00AA01AC);
    send(8'h7E); send(8'h04); send(8'hAC); send(8'h01); send(8'hAA); send(8'h00);
    send(8'hF4);
    // test 3: bad lengths, held message
    send(8'h7E);
    expect_ev(1, 8'hAC, 4, 80'h00AA01AC);
    send(8'h00);
    send(8'h7E);
    expect_ev(1, 8'hAC, 4, 80'h00AA01AC);
    send(8'h0B);
    // test 4: timeout, then a 1-byte frame
    send(8'h7E);
    chk("busy_after_sync", busy, 1);
    send(8'h03); send(8'hA8);
    expect_ev(1, 8'hAC, 4, 80'h00AA01AC, cyc + T);
    repeat (T + 5) @(negedge CLK);
    chk("busy_after_timeout", busy, 0);
    expect_ev(0, 8'hA8, 1, 80'hA8);
    send(8'h7E); send(8'h01); send(8'hA8);
    // test 5: 7E as data, framing errors
    expect_ev(0, 8'h7E, 3, 80'h7E7E7E);
    send(8'h7E); send(8'h03); send(8'h7E); send(8'h7E); send(8'h7E);
    send(8'h7E); send(8'h02);
    expect_ev(1, 8'h7E, 3, 80'h7E7E7E);
    ferr_pulse();
    send(8'h7E); send(8'h01);
    expect_ev(1, 8'h7E, 3, 80'h7E7E7E);
    send(8'hAC, 1'b1);
    ferr_pulse();
    chk("busy_idle_ferr", busy, 0);
    // test 6: reset mid-frame
    send(8'h7E); send(8'h04); send(8'hAC); send(8'h01);
    @(negedge CLK);
    reset = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    repeat (2) @(negedge CLK);
    reset = 1'b1;
    send(8'h7E); send(8'h04);
    expect_ev(0, 8'hA8, 4, 80'h000000A8);
    send(8'hA8); send(8'h00); send(8'h00); send(8'h00);
    repeat (10) @(negedge CLK);
    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
